// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal RAM with independent read and write burst engines.
// FIXED and INCR bursts (WRAP is treated as INCR); every beat is range-checked.
module axi_mem_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [1:0]                s_axi_arburst,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [1:0]                s_axi_awburst,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready
);
  localparam int LSB    = $clog2(DATA_WIDTH / 8);
  localparam int HI     = LSB + MEM_DEPTH_LOG2;
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, r_next_addr;
  logic [7:0]            rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic                  rfixed_q, rfixed_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d, rvalid_q, rvalid_d, r_load;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, w_next_addr;
  logic [8:0]            wcnt_q, wcnt_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic                  wfixed_q, wfixed_d, werr_q, werr_d, mem_we, w_oor;

  assign r_next_addr = rfixed_q ? raddr_q : raddr_q + (ADDR_WIDTH'(1) << rsize_q);
  assign w_next_addr = wfixed_q ? waddr_q : waddr_q + (ADDR_WIDTH'(1) << wsize_q);
  assign w_oor       = |waddr_q[ADDR_WIDTH-1:HI];

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rfixed_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rfixed_q  <= rfixed_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
    end
  end

  // Read engine: the next word is fetched on the same edge as the current beat's handshake.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rfixed_d  = rfixed_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_load    = 1'b1;
          raddr_d   = s_axi_araddr;
          rcnt_d    = s_axi_arlen;
          rsize_d   = s_axi_arsize;
          rfixed_d  = (s_axi_arburst == 2'b00);
          rlast_d   = (s_axi_arlen == 8'd0);
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rcnt_q == 8'd0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_load  = 1'b1;
            raddr_d = r_next_addr;
            rcnt_d  = rcnt_q - 8'd1;
            rlast_d = (rcnt_q == 8'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      if (|raddr_d[ADDR_WIDTH-1:HI]) begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end else begin
        rdata_d = mem_q[raddr_d[LSB +: MEM_DEPTH_LOG2]];
        rresp_d = 2'b00;
      end
    end
  end

  // Write engine: wcnt_q counts accepted beats; it saturates since the error flag is sticky.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wcnt_d    = wcnt_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          waddr_d   = s_axi_awaddr;
          wlen_d    = s_axi_awlen;
          wsize_d   = s_axi_awsize;
          wfixed_d  = (s_axi_awburst == 2'b00);
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          if (w_oor) werr_d = 1'b1;
          else       mem_we = 1'b1;
          if (s_axi_wlast) begin
            if (wcnt_q != {1'b0, wlen_q}) werr_d = 1'b1;
            w_state_d = W_RESP;
          end else begin
            if (wcnt_q >= {1'b0, wlen_q}) werr_d = 1'b1;
            if (wcnt_q != 9'h1FF) wcnt_d = wcnt_q + 9'd1;
            waddr_d = w_next_addr;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          werr_d    = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // RAM is never reset; nonblocking writes make same-edge reads return the old word.
  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem_q[waddr_q[LSB +: MEM_DEPTH_LOG2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = (w_state_q == W_RESP && werr_q) ? 2'b10 : 2'b00;

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 memory-mapped slave backed by an internal RAM. It serves INCR and FIXED read and write bursts issued by the dma block's mm2s and s2mm masters. It is the bring-up and simulation target for DMA transfers, so the JPEG2000 datapath can be exercised without external DDR. The read and write channels are independent and run concurrently.

Parameters:
DATA_WIDTH, 64, data bus width in bits (power of two, >= 32); must match the dma block's DMA_DATA_WIDTH_SRC.
ADDR_WIDTH, 32, address width; must match DMA_AXI_ADDR_WIDTH.
MEM_DEPTH_LOG2, 10, log2 of RAM depth in DATA_WIDTH words (default 1024 words, 8 KiB).

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_araddr  in  ADDR_WIDTH  read burst start address
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes per beat (<= log2(DATA_WIDTH/8))
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
s_axi_awaddr  in  ADDR_WIDTH  write burst start address
s_axi_awburst  in  2  as arburst
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  as arsize
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready

Behaviour:
- Reset (async assert, sync release): arready=1, awready=1, rvalid=0, rlast=0, rresp=0, rdata=0, wready=0, bvalid=0, bresp=0. Both FSMs go to IDLE. RAM contents are not cleared. Reset mid-burst abandons the burst; no partial response is issued.
- Address map: LSB = log2(DATA_WIDTH/8). Word index = addr[LSB +: MEM_DEPTH_LOG2]. A beat is out-of-range if any addr bit above LSB+MEM_DEPTH_LOG2 is set.
- Beat address: FIXED holds the start address. INCR/WRAP add (1<<size) per beat, at ADDR_WIDTH width with natural wrap. The 4 KiB rule is not checked.
- Narrow beats: reads return the full word; writes honour wstrb only. Lane steering is the master's job.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch addr/len/size/burst and load beat counter = arlen. Go to R_DATA with rvalid=1 on the next cycle, rdata = word at start address (1-cycle latency).
  - R_DATA: arready=0. rdata/rresp/rlast hold stable while rvalid&!rready.
  - On each handshake with beats remaining, the next word loads on the same edge, giving 1 beat/clock under continuous rready.
  - rlast=1 when the counter is 0. The handshake on the rlast beat drops rvalid and returns to R_IDLE; the next AR may be accepted the following cycle.
  - Out-of-range beat: rdata=0, rresp=10. Each beat carries its own rresp.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch fields and go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata under wstrb, unless out-of-range (dropped, error flag set). The burst ends on the beat with wlast=1.
  - W_DATA error flag is also set if wlast arrives on the wrong beat, i.e. the count differs from awlen+1. Extra beats past awlen without wlast are written at their incremented address and set the flag.
  - W_RESP: wready=0, bvalid=1, bresp = flag ? 10 : 00. Hold until bready, then clear the flag and go to W_IDLE.
  - W data arriving before AW is not accepted (wready=0 in W_IDLE).
- Simultaneous read and write of the same word on the same edge is read-first: the read beat returns the old data.
- Read and write bursts overlap freely; there is no ordering between channels.

Test Plan:
- Write INCR awaddr=0x100, awlen=3, awsize=3, data 0x1111…, 0x2222…, 0x3333…, 0x4444…, wstrb=0xFF; then read the same burst -> bresp=00; 4 R beats with matching data, rlast only on beat 4, rresp=00, first rvalid 1 cycle after AR handshake.
- Read arlen=7 with rready toggling 1/0 each cycle -> 8 beats in order; rdata/rlast stable while rready=0; arready=0 until the last handshake.
- Word at 0x40 preset to 0xAAAAAAAA_AAAAAAAA; write 0x55555555_55555555 with wstrb=0x0F -> readback 0xAAAAAAAA_55555555.
- araddr=0x2000 (default depth), arlen=0; awaddr=0x2000 writing 0xDEAD… -> rdata=0, rresp=10, bresp=10; word 0x0 unchanged.
- awlen=3 with wlast on beat 2 -> 2 words written, bresp=10; the next AW is accepted after the B handshake.
- Read arlen=7 at 0x0; deassert aresetn after beat 2 -> rvalid=0 immediately; after release, arready=1 and a new read returns the previously written data (RAM retained).
